// File: rtl/noc_arb_pkg.sv
// Shared types and flit helpers for the NoC read-side arbiter.
// Flit control bits are located by index, so one helper serves any flit width.
package noc_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 34;
    localparam int DEFAULT_HEAD_BIT   = 33;
    localparam int DEFAULT_TAIL_BIT   = 32;

    // Widest flit the helpers accept; narrower flits are zero-extended by the caller.
    localparam int FLIT_MAX_W = 256;
    localparam int FLIT_IDX_W = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] flit_t;

    function automatic logic is_head(input logic [FLIT_MAX_W-1:0] flit,
                                     input int unsigned head_bit = DEFAULT_HEAD_BIT);
        return flit[head_bit[FLIT_IDX_W-1:0]];
    endfunction

    function automatic logic is_tail(input logic [FLIT_MAX_W-1:0] flit,
                                     input int unsigned tail_bit = DEFAULT_TAIL_BIT);
        return flit[tail_bit[FLIT_IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/dcfifo_read_arbiter_if.sv
// FIFO read ports and output link of the arbiter, bundled as one interface.
// master = arbiter side, slave = FIFOs plus downstream link.
interface dcfifo_read_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
    localparam int IDX_W = $clog2(NUM_FIFO);

    logic [NUM_FIFO-1:0]            fifo_empty;
    logic [NUM_FIFO*DATA_WIDTH-1:0] fifo_data;
    logic [NUM_FIFO-1:0]            fifo_rd;
    logic                           out_valid;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [IDX_W-1:0]               out_src;
    logic                           out_ready;
    logic                           err_no_head;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd, out_valid, out_data, out_src, err_no_head
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd, out_valid, out_data, out_src, err_no_head
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit compare keeps non-power-of-2 N from stepping past N-1.
            cand = (int'(ptr) + k >= N) ? IDX_W'(int'(ptr) + k - N) : IDX_W'(int'(ptr) + k);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcfifo_read_arbiter.sv
// Packet-granular round-robin scheduler sharing one output link among show-ahead
// dual-clock FIFOs, with a registered valid/ready output stage.
module dcfifo_read_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int HEAD_BIT   = DEFAULT_HEAD_BIT,
    parameter int TAIL_BIT   = DEFAULT_TAIL_BIT
) (
    input logic                   clk,
    input logic                   rst,
    dcfifo_read_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_FIFO);
    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t            state;
    idx_t                  rr_ptr;
    idx_t                  owner;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    idx_t                  out_src_q;
    logic                  err_q;

    logic [NUM_FIFO-1:0]   req;
    logic [NUM_FIFO-1:0]   win_grant;
    idx_t                  win_idx;
    logic                  win_any;
    logic [NUM_FIFO-1:0]   sel_onehot;
    idx_t                  sel_idx;
    logic                  sel_ready;
    logic                  space;
    logic                  pop;
    logic                  pop_head;
    logic                  pop_tail;
    logic [DATA_WIDTH-1:0] head_flit [NUM_FIFO];
    logic [DATA_WIDTH-1:0] sel_flit;

    function automatic idx_t wrap_inc(input idx_t i);
        return (i == idx_t'(NUM_FIFO - 1)) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_head
        assign head_flit[g] = bus.fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req = ~bus.fifo_empty;

    rr_arbiter #(.N(NUM_FIFO)) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .any_grant (win_any)
    );

    // While a packet is in flight only its owner may be popped.
    always_comb begin
        sel_idx    = win_idx;
        sel_onehot = win_grant;
        sel_ready  = win_any;
        if (state == LOCKED) begin
            sel_idx             = owner;
            sel_onehot          = '0;
            sel_onehot[owner]   = 1'b1;
            sel_ready           = ~bus.fifo_empty[owner];
        end
    end

    assign space    = ~out_valid_q | bus.out_ready;
    // NOTE: the pop strobe is combinational, so it is gated by rst to stay low during reset.
    assign pop      = ~rst & space & sel_ready;
    assign sel_flit = head_flit[sel_idx];
    assign pop_head = is_head(FLIT_MAX_W'(sel_flit), HEAD_BIT);
    assign pop_tail = is_tail(FLIT_MAX_W'(sel_flit), TAIL_BIT);

    assign bus.fifo_rd     = pop ? sel_onehot : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_src     = out_src_q;
    assign bus.err_no_head = err_q;

    // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_flit;
                out_src_q   <= sel_idx;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (!pop_head) err_q <= 1'b1;
                        if (pop_tail) begin
                            rr_ptr <= wrap_inc(sel_idx);
                        end else begin
                            state <= LOCKED;
                            owner <= sel_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (pop && pop_tail) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcfifo_read_arbiter.sv
// Self-checking bench: FIFO queue models feed two arbiters (4 and 3 ports); a
// scoreboard of expected {src, flit} is compared on every output handshake.
module tb_dcfifo_read_arbiter;
    import noc_arb_pkg::*;

    localparam int DW = 34;
    typedef logic [DW-1:0] fl_t;
    typedef struct packed { logic [1:0] src; fl_t flit; } exp_t;
    typedef struct packed { logic [3:0] mask; logic [7:0] order; logic [3:0] n; } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcfifo_read_arbiter_if #(.NUM_FIFO(4), .DATA_WIDTH(DW)) bus4 ();
    dcfifo_read_arbiter_if #(.NUM_FIFO(3), .DATA_WIDTH(DW)) bus3 ();

    dcfifo_read_arbiter #(.NUM_FIFO(4), .DATA_WIDTH(DW)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dcfifo_read_arbiter #(.NUM_FIFO(3), .DATA_WIDTH(DW)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    fl_t  fq4 [4][$];
    fl_t  fq3 [3][$];
    exp_t exp4 [$];
    exp_t exp3 [$];
    logic [3:0] rd_tr [$];
    logic       ov_tr [$];

    int n_checks = 0;
    int n_errs   = 0;

    logic [3:0] exp_rd_pkt [5]  = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    logic       exp_ov_pkt [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_rd_gap [10] = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic fl_t mk(input logic h, input logic t, input int src, input int tag, input int part);
        return {h, t, 8'(src), 8'(tag), 16'(part)};
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            bus4.fifo_empty[i]        = (fq4[i].size() == 0);
            bus4.fifo_data[i*DW +: DW] = (fq4[i].size() != 0) ? fq4[i][0] : '0;
        end
        for (int i = 0; i < 3; i++) begin
            bus3.fifo_empty[i]        = (fq3[i].size() == 0);
            bus3.fifo_data[i*DW +: DW] = (fq3[i].size() != 0) ? fq3[i][0] : '0;
        end
    endtask

    // One clock: present FIFO heads, observe at the falling edge, pop after the rising edge.
    task automatic cycle();
        logic [3:0] rd4;
        logic [2:0] rd3;
        exp_t       e;
        drive_fifos();
        @(negedge clk);
        rd4 = bus4.fifo_rd;
        rd3 = bus3.fifo_rd;
        check("rd_legal4", 64'(((rd4 & bus4.fifo_empty) == 0) && $onehot0(rd4) &&
              ((!bus4.out_valid || bus4.out_ready) || rd4 == 0)), 64'd1);
        check("rd_legal3", 64'(((rd3 & bus3.fifo_empty) == 0) && $onehot0(rd3) &&
              ((!bus3.out_valid || bus3.out_ready) || rd3 == 0)), 64'd1);
        rd_tr.push_back(rd4);
        ov_tr.push_back(bus4.out_valid);
        if (bus4.out_valid && bus4.out_ready) begin
            check("sb_has_entry4", 64'(exp4.size() != 0), 64'd1);
            if (exp4.size() != 0) begin
                e = exp4.pop_front();
                check("out_src4", 64'(bus4.out_src), 64'(e.src));
                check("out_data4", 64'(bus4.out_data), 64'(e.flit));
            end
        end
        if (bus3.out_valid && bus3.out_ready) begin
            check("sb_has_entry3", 64'(exp3.size() != 0), 64'd1);
            if (exp3.size() != 0) begin
                e = exp3.pop_front();
                check("out_src3", 64'(bus3.out_src), 64'(e.src));
                check("out_data3", 64'(bus3.out_data), 64'(e.flit));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (rd4[i] && fq4[i].size() != 0) fq4[i].delete(0);
        for (int i = 0; i < 3; i++) if (rd3[i] && fq3[i].size() != 0) fq3[i].delete(0);
    endtask

    function automatic logic busy();
        logic b;
        b = (exp4.size() != 0) || (exp3.size() != 0) || bus4.out_valid || bus3.out_valid;
        for (int i = 0; i < 4; i++) if (fq4[i].size() != 0) b = 1'b1;
        for (int i = 0; i < 3; i++) if (fq3[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string name);
        int left;
        left = 50;
        while (busy() && left > 0) begin
            cycle();
            left--;
        end
        check({name, "_drained"}, 64'(busy()), 64'd0);
    endtask

    task automatic push4(input int f, input fl_t fl);
        fq4[f].push_back(fl);
        exp4.push_back({2'(f), fl});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       vec [7];
        logic [1:0] s;
        fl_t        fl;

        // Single-flit packets loaded together; order lists expected grants, first in bits [1:0].
        vec[0] = '{4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4'd4};
        vec[1] = '{4'b1010, {2'd0, 2'd0, 2'd3, 2'd1}, 4'd2};
        vec[2] = '{4'b0101, {2'd0, 2'd0, 2'd2, 2'd0}, 4'd2};
        vec[3] = '{4'b0111, {2'd0, 2'd2, 2'd1, 2'd0}, 4'd3};
        vec[4] = '{4'b1001, {2'd0, 2'd0, 2'd0, 2'd3}, 4'd2};
        vec[5] = '{4'b0001, {2'd0, 2'd0, 2'd0, 2'd0}, 4'd1};
        vec[6] = '{4'b1100, {2'd0, 2'd0, 2'd3, 2'd2}, 4'd2};

        rst            = 1'b1;
        bus4.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        drive_fifos();
        #12;
        check("reset_valid4", 64'(bus4.out_valid), 64'd0);
        check("reset_data4", 64'(bus4.out_data), 64'd0);
        check("reset_src4", 64'(bus4.out_src), 64'd0);
        check("reset_err4", 64'(bus4.err_no_head), 64'd0);
        check("reset_rd4", 64'(bus4.fifo_rd), 64'd0);
        check("reset_valid3", 64'(bus3.out_valid), 64'd0);
        check("reset_err3", 64'(bus3.err_no_head), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin order across single-flit packets, 1 flit/cycle.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++)
                if (vec[v].mask[i]) fq4[i].push_back(mk(1'b1, 1'b1, i, 10 + v, 0));
            for (int k = 0; k < int'(vec[v].n); k++) begin
                s = vec[v].order[k*2 +: 2];
                exp4.push_back({s, mk(1'b1, 1'b1, int'(s), 10 + v, 0)});
            end
            for (int c = 0; c <= int'(vec[v].n); c++) cycle();
            check("vec_back_to_back", 64'(exp4.size()), 64'd0);
            drain("vec");
        end

        // 3-flit packet from FIFO 0: three consecutive pops, output one cycle later.
        rd_tr.delete();
        ov_tr.delete();
        for (int p = 0; p < 3; p++) push4(0, mk(p == 0, p == 2, 0, 20, p));
        repeat (5) cycle();
        for (int j = 0; j < 5; j++) begin
            check("pkt3_rd", 64'(rd_tr[j]), 64'(exp_rd_pkt[j]));
            check("pkt3_valid", 64'(ov_tr[j]), 64'(exp_ov_pkt[j]));
        end
        drain("pkt3");

        // rr_ptr now 1: FIFO 1 must beat FIFO 0.
        fq4[0].push_back(mk(1'b1, 1'b1, 0, 21, 0));
        fq4[1].push_back(mk(1'b1, 1'b1, 1, 21, 0));
        exp4.push_back({2'd1, mk(1'b1, 1'b1, 1, 21, 0)});
        exp4.push_back({2'd0, mk(1'b1, 1'b1, 0, 21, 0)});
        drain("rr_ptr_after_pkt");

        // Owner runs dry mid-packet: no other FIFO granted until its tail.
        rd_tr.delete();
        push4(1, mk(1'b1, 1'b0, 1, 30, 0));
        push4(1, mk(1'b0, 1'b0, 1, 30, 1));
        fq4[2].push_back(mk(1'b1, 1'b1, 2, 30, 9));
        repeat (7) cycle();
        push4(1, mk(1'b0, 1'b0, 1, 30, 2));
        push4(1, mk(1'b0, 1'b1, 1, 30, 3));
        exp4.push_back({2'd2, mk(1'b1, 1'b1, 2, 30, 9)});
        repeat (3) cycle();
        for (int j = 0; j < 10; j++) check("gap_rd", 64'(rd_tr[j]), 64'(exp_rd_gap[j]));
        drain("gap");

        // Backpressure for 4 cycles mid-packet.
        for (int p = 0; p < 3; p++) push4(3, mk(p == 0, p == 2, 3, 40, p));
        cycle();
        cycle();
        bus4.out_ready = 1'b0;
        fl = mk(1'b0, 1'b0, 3, 40, 1);
        repeat (4) begin
            cycle();
            check("stall_valid", 64'(bus4.out_valid), 64'd1);
            check("stall_data", 64'(bus4.out_data), 64'(fl));
            check("stall_src", 64'(bus4.out_src), 64'd3);
            check("stall_rd", 64'(bus4.fifo_rd), 64'd0);
        end
        bus4.out_ready = 1'b1;
        drain("stall");

        // Packet start without head bit sets the sticky error.
        push4(3, mk(1'b0, 1'b0, 3, 50, 0));
        push4(3, mk(1'b0, 1'b1, 3, 50, 1));
        check("err_before_pop", 64'(bus4.err_no_head), 64'd0);
        cycle();
        check("err_after_pop", 64'(bus4.err_no_head), 64'd1);
        drain("no_head");
        check("err_sticky", 64'(bus4.err_no_head), 64'd1);

        // Asynchronous reset with a flit in the output stage and a pop pending.
        fq4[0].push_back(mk(1'b1, 1'b1, 0, 60, 0));
        fq4[0].push_back(mk(1'b1, 1'b1, 0, 60, 1));
        cycle();
        drive_fifos();
        #1;
        check("pre_rst_valid", 64'(bus4.out_valid), 64'd1);
        check("pre_rst_rd", 64'(bus4.fifo_rd), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(bus4.out_valid), 64'd0);
        check("rst_err", 64'(bus4.err_no_head), 64'd0);
        check("rst_rd", 64'(bus4.fifo_rd), 64'd0);
        check("rst_data", 64'(bus4.out_data), 64'd0);
        check("rst_src", 64'(bus4.out_src), 64'd0);
        fq4[0].delete();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_err", 64'(bus4.err_no_head), 64'd0);

        // Three-port instance: continuous traffic, grants 0,1,2,0,1,2.
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 3; i++) begin
                fq3[i].push_back(mk(1'b1, 1'b1, i, 70, j));
                exp3.push_back({2'(i), mk(1'b1, 1'b1, i, 70, j)});
            end
        repeat (7) cycle();
        check("n3_back_to_back", 64'(exp3.size()), 64'd0);
        drain("n3");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dcfifo_read_arbiter.md
Name: dcfifo_read_arbiter

Overview:
Read-clock-domain scheduler that shares one NoC output link among NUM_FIFO dual-clock FIFOs. These are per-VC or per-source CDC FIFOs with show-ahead read ports: head data is valid whenever not empty, and a pop is rd & !empty.
The block arbitrates round-robin at packet granularity. Once a head flit is granted, the FIFO stays granted until its tail flit is popped.
Flits go out through a single registered output stage with valid/ready backpressure.

Parameters:
NUM_FIFO, 4, number of FIFO read ports arbitrated (>=2)
DATA_WIDTH, 34, flit width including control bits
HEAD_BIT, 33, index of head-flit marker in flit
TAIL_BIT, 32, index of tail-flit marker in flit

Ports:
clk  in  1  read-side clock (same as FIFO read clock)
rst  in  1  asynchronous, active-high reset
fifo_empty  in  NUM_FIFO  per-FIFO empty flag
fifo_data  in  NUM_FIFO*DATA_WIDTH  per-FIFO head flit, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
fifo_rd  out  NUM_FIFO  per-FIFO pop strobe (one-hot or zero)
out_valid  out  1  output flit valid
out_data  out  DATA_WIDTH  output flit
out_src  out  $clog2(NUM_FIFO)  index of FIFO the output flit came from
out_ready  in  1  downstream accepts flit
err_no_head  out  1  sticky: packet start lacked head bit

Behaviour:
- Reset (async): out_valid=0, out_data=0, out_src=0, fifo_rd=0, err_no_head=0, state=IDLE, rr_ptr=0, owner=0.
- space = !out_valid | out_ready. fifo_rd must never assert when !space or when the selected FIFO is empty.
- State IDLE:
  - Candidates are FIFOs with !fifo_empty.
  - Winner is the first candidate at or after rr_ptr, wrapping modulo NUM_FIFO.
  - If a winner exists and space: pop it (fifo_rd[w]=1) in the same cycle.
  - Flit has tail bit (single-flit packet): stay IDLE, rr_ptr <= w+1 mod NUM_FIFO.
  - Otherwise: go LOCKED, owner <= w.
  - Flit lacks head bit: err_no_head <= 1 (sticky until reset); the flit is still forwarded.
- State LOCKED:
  - Only the owner is eligible. Pop when !fifo_empty[owner] & space.
  - Owner empty mid-packet: wait with no pop and no timeout. Other FIFOs are never granted.
  - Tail flit popped: go IDLE, rr_ptr <= owner+1 mod NUM_FIFO.
- Output register, on any pop: out_valid<=1, out_data<=popped flit, out_src<=index.
  - Else if out_ready: out_valid<=0.
  - out_data/out_src hold value while out_valid & !out_ready.
- Latency: flit visible at out_valid one cycle after its pop. Sustained throughput is 1 flit/cycle with out_ready held high, including across packet boundaries (IDLE re-arbitrates in the cycle after the tail pop).
- Simultaneous events:
  - Pop and out_ready in the same cycle: new flit replaces the old one; no bubble.
  - Head+tail in one flit: treated as a complete packet.
- rr_ptr wrap: NUM_FIFO-1 -> 0. A non-power-of-2 NUM_FIFO must wrap correctly (explicit compare, not bit truncation).
- Mid-packet reset returns to IDLE immediately. Residual flits are discarded by the FIFOs' own reset (shared rst).

Decomposition:
- Package noc_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}
  - flit_t typedef (logic [DATA_WIDTH-1:0])
  - default HEAD_BIT/TAIL_BIT localparams
  - function is_head/is_tail
- Sub-module rr_arbiter: purely combinational. Inputs are the req vector and rr_ptr; outputs are grant one-hot, grant index, and any-grant. Top keeps the FSM, owner, rr_ptr, and output register.

Test Plan:
- Single FIFO 0 loaded with 3-flit packet (H,B,T), out_ready=1 -> fifo_rd[0] on 3 consecutive cycles; out_valid 3 cycles starting 1 cycle later; out_src=0; ends IDLE with rr_ptr=1.
- FIFOs 0..3 each hold one single-flit packet (H+T), rr_ptr=0 -> out_src sequence 0,1,2,3 on back-to-back cycles; rr_ptr wraps to 0.
- FIFO 1 holds a 4-flit packet and FIFO 2 holds a 1-flit packet, with FIFO 1 going empty after flit 2 for 5 cycles -> no fifo_rd[2] until FIFO 1's tail popped; then FIFO 2 is granted the next cycle.
- out_ready=0 for 4 cycles mid-packet -> exactly one flit held stable on out_data, fifo_rd=0 during stall, no flit lost or duplicated on release.
- First flit of FIFO 3 lacks head bit -> err_no_head rises the cycle after the pop and stays 1. Asserting rst clears it and out_valid asynchronously.
- NUM_FIFO=3, continuous traffic on all three -> grant order 0,1,2,0; no index 3 ever appears.
